perlane_descrambler_n: RTL and testbench

PERLANE_DESCRAMBLER_N -- requirements
Module: perlane_descrambler_n

---
 rtl/perlane_descrambler_n.sv | 129 ++++++++++++
 tb/tb_perlane_descrambler_n.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/perlane_descrambler_n.sv
// perlane_descrambler_n: LANES independent 64-bit self-synchronising
// descramblers (1 + x^39 + x^58) sharing one valid/error/primed path.
// Optional feature: define PERLANE_DESCR_BYPASS_EN to add in_bypass, which
// passes in_txdata through unmodified and drops the not-primed error term.
module perlane_descrambler_n #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_enable,
    input  logic [64*LANES-1:0]   in_txdata,
    input  logic                  in_txdata_valid,
    input  logic                  in_txdata_error,
`ifdef PERLANE_DESCR_BYPASS_EN
    input  logic                  in_bypass,
`endif
    input  logic                  in_idle,
    output logic [64*LANES-1:0]   out_txdata,
    output logic                  out_txdata_valid,
    output logic                  out_txdata_error,
    output logic                  out_primed,
    output logic [CNT_W-1:0]      out_err_cnt,
    output logic                  out_idle
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned HIST_W = 58;
    localparam int unsigned TAP_A  = 39;
    localparam int unsigned DATA_W = WORD_W * LANES;
    localparam int unsigned EXT_W  = WORD_W + HIST_W;

    // Shared control state
    logic               primed_q, primed_d;
    logic               last_err_q, last_err_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;

    // Per-lane history and combinational descrambled word
    logic [LANES-1:0][HIST_W-1:0] hist_q, hist_d;
    logic [DATA_W-1:0]            descr_c;

    logic accept_c;
    logic bypass_c;

    assign accept_c = in_enable & in_txdata_valid;

`ifdef PERLANE_DESCR_BYPASS_EN
    assign bypass_c = in_bypass;
`else
    assign bypass_c = 1'b0;
`endif

    // Idle indication is a plain combinational pass-through
    assign out_idle = in_idle;

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        logic [WORD_W-1:0] word_c;
        logic [EXT_W-1:0]  ext_c;

        assign word_c = in_txdata[k*WORD_W +: WORD_W];

        // Bit i of ext_c is wire index i-58: history below, current word above
        always_comb begin
            ext_c = {word_c, hist_q[k]};
            descr_c[k*WORD_W +: WORD_W] = ext_c[EXT_W-1:HIST_W]
                                        ^ ext_c[WORD_W+HIST_W-TAP_A-1:HIST_W-TAP_A]
                                        ^ ext_c[WORD_W-1:0];
        end

        // History tracks the top 58 bits of the last accepted word
        always_comb begin
            hist_d[k] = hist_q[k];
            if (accept_c) begin
                hist_d[k] = word_c[WORD_W-1:WORD_W-HIST_W];
            end
        end
    end

    // Shared valid/error/primed/counter next-state
    always_comb begin
        primed_d   = primed_q;
        last_err_d = last_err_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        if (accept_c) begin
            valid_d    = 1'b1;
            err_d      = in_txdata_error | last_err_q | (~primed_q & ~bypass_c);
            last_err_d = in_txdata_error;
            primed_d   = 1'b1;
            data_d     = bypass_c ? in_txdata : descr_c;
            if (err_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q     <= '0;
            primed_q   <= 1'b0;
            last_err_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
        end else begin
            hist_q     <= hist_d;
            primed_q   <= primed_d;
            last_err_q <= last_err_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
        end
    end

    assign out_txdata       = data_q;
    assign out_txdata_valid = valid_q;
    assign out_txdata_error = err_q;
    assign out_primed       = primed_q;
    assign out_err_cnt      = cnt_q;

endmodule

// File: tb/tb_perlane_descrambler_n.sv
// Bench for perlane_descrambler_n: directed cases plus randomized scrambled
// traffic checked against a bit-level reference model.
module tb_perlane_descrambler_n;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 64 * LANES;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic            clk;
    logic            reset_n;
    logic            in_enable;
    logic [DW-1:0]   in_txdata;
    logic            in_txdata_valid;
    logic            in_txdata_error;
    logic            in_idle;
`ifdef PERLANE_DESCR_BYPASS_EN
    logic            in_bypass;
`endif
    logic [DW-1:0]   out_txdata;
    logic            out_txdata_valid;
    logic            out_txdata_error;
    logic            out_primed;
    logic [CNT_W-1:0] out_err_cnt;
    logic            out_idle;

    perlane_descrambler_n #(.LANES(LANES), .CNT_W(CNT_W)) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_enable        (in_enable),
        .in_txdata        (in_txdata),
        .in_txdata_valid  (in_txdata_valid),
        .in_txdata_error  (in_txdata_error),
`ifdef PERLANE_DESCR_BYPASS_EN
        .in_bypass        (in_bypass),
`endif
        .in_idle          (in_idle),
        .out_txdata       (out_txdata),
        .out_txdata_valid (out_txdata_valid),
        .out_txdata_error (out_txdata_error),
        .out_primed       (out_primed),
        .out_err_cnt      (out_err_cnt),
        .out_idle         (out_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0]   m_prev [LANES];
    logic          m_primed;
    logic          m_last_err;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_err;
    int            exp_cnt;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wire bit j of the lane: j>=0 in the current word, j<0 in the previous one
    function automatic logic wire_bit(input logic [63:0] cur, input logic [63:0] prev, input int j);
        return (j >= 0) ? cur[j] : prev[64 + j];
    endfunction

    function automatic logic [63:0] descr(input logic [63:0] cur, input logic [63:0] prev);
        logic [63:0] o;
        for (int i = 0; i < 64; i++)
            o[i] = cur[i] ^ wire_bit(cur, prev, i - 39) ^ wire_bit(cur, prev, i - 58);
        return o;
    endfunction

    // Serial scrambler whose transmitted history is the previous sent word
    function automatic logic [63:0] scramble(input logic [63:0] d, input logic [63:0] prev);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 64; i++)
            s[i] = d[i] ^ wire_bit(s, prev, i - 39) ^ wire_bit(s, prev, i - 58);
        return s;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic step(input logic rst, input logic en, input logic v, input logic e,
                        input logic [DW-1:0] d);
        logic err;
        reset_n         = !rst;
        in_enable       = en;
        in_txdata_valid = v;
        in_txdata_error = e;
        in_txdata       = d;
        in_idle         = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < int'(LANES); k++) m_prev[k] = '0;
            m_primed = 0; m_last_err = 0; exp_data = '0;
            exp_valid = 0; exp_err = 0; exp_cnt = 0;
        end else if (en && v) begin
            err = e | m_last_err | !m_primed;
            for (int k = 0; k < int'(LANES); k++) begin
                exp_data[64*k +: 64] = descr(d[64*k +: 64], m_prev[k]);
                m_prev[k] = d[64*k +: 64];
            end
            exp_valid = 1; exp_err = err; m_last_err = e; m_primed = 1;
            if (err && exp_cnt < CMAX) exp_cnt++;
        end else begin
            exp_valid = 0;
        end
        #1;
        check("data",   out_txdata, exp_data);
        check("valid",  DW'(out_txdata_valid), DW'(exp_valid));
        check("error",  DW'(out_txdata_error), DW'(exp_err));
        check("primed", DW'(out_primed), DW'(m_primed));
        check("errcnt", DW'(out_err_cnt), DW'(exp_cnt));
        check("idle",   DW'(out_idle), DW'(in_idle));
    endtask

    logic [DW-1:0] w;
    logic [DW-1:0] plain;

    initial begin
        reset_n = 0; in_enable = 0; in_txdata = '0; in_txdata_valid = 0;
        in_txdata_error = 0; in_idle = 0;
`ifdef PERLANE_DESCR_BYPASS_EN
        in_bypass = 0;
`endif
        @(posedge clk); #1;

        // Words presented during reset are discarded
        step(1, 1, 1, 1, rand_word());
        step(1, 1, 1, 0, rand_word());

        // Four zero words: only word 0 flagged, count ends at 1
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, '0);
        check("zero_cnt", DW'(out_err_cnt), DW'(1));

        // Single bit 0 in lane 0 hits taps 39 and 58 within the word
        w = '0; w[0] = 1'b1;
        step(0, 1, 1, 0, w);
        check("bit0_w", DW'(out_txdata[63:0]), DW'(64'h0400_0080_0000_0001));
        step(0, 1, 1, 0, '0);
        check("bit0_n", DW'(out_txdata[63:0]), DW'(0));

        // Bit 63 carries over into bits 38 and 57 of the next word
        w = '0; w[63] = 1'b1;
        step(0, 1, 1, 0, w);
        check("bit63_w", DW'(out_txdata[63:0]), DW'(64'h8000_0000_0000_0000));
        step(0, 1, 1, 0, '0);
        check("bit63_n", DW'(out_txdata[63:0]), DW'(64'h0200_0040_0000_0000));

        // Errored word flags itself and the next word
        step(0, 1, 1, 1, rand_word());
        check("err_n", DW'(out_txdata_error), DW'(1));
        step(0, 1, 1, 0, rand_word());
        check("err_n1", DW'(out_txdata_error), DW'(1));
        step(0, 1, 1, 0, rand_word());
        check("err_n2", DW'(out_txdata_error), DW'(0));
        check("err_cnt", DW'(out_err_cnt), DW'(3));

        // Enable gap with valid held high freezes the lanes
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, rand_word());
        step(0, 1, 1, 0, rand_word());

        // Randomized scrambled traffic: lanes recover the plaintext
        for (int n = 0; n < 300; n++) begin
            logic en, v, e;
            en = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 7) != 0);
            e  = ($urandom_range(0, 31) == 0);
            plain = rand_word();
            for (int k = 0; k < int'(LANES); k++)
                w[64*k +: 64] = scramble(plain[64*k +: 64], m_prev[k]);
            step(0, en, v, e, w);
            if (en && v) begin
                for (int k = 0; k < int'(LANES); k++)
                    check("recover", DW'(out_txdata[64*k +: 64]), DW'(plain[64*k +: 64]));
            end
        end

        // Mid-stream reset forces re-priming
        step(1, 1, 1, 0, rand_word());
        step(0, 0, 0, 0, rand_word());
        step(0, 1, 1, 0, rand_word());
        check("rearm_err", DW'(out_txdata_error), DW'(1));

        // Counter saturation
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1, rand_word());
        check("sat_cnt", DW'(out_err_cnt), DW'(15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
